// File: rtl/ltc2308_responder_if.sv
// ---------------------------------------------------------------------------
// ltc2308_responder_if : 4-wire LTC2308 serial link (cs/sck/mosi/miso). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ltc2308_responder_if;
  logic cs;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output cs, output sck, output mosi, input miso);
  modport slave  (input cs, input sck, input mosi, output miso);
endinterface

`default_nettype wire

// File: rtl/ltc2308_responder.sv
// ---------------------------------------------------------------------------
// ltc2308_responder : oversampled LTC2308 ADC emulator for hardware-in-loop tests. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ltc2308_responder #(
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6,
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic                  clk_50,
  input  wire logic                  reset_n,
  ltc2308_responder_if.slave         spi,
  input  wire logic [8*DATA_W-1:0]   ch_data,
  output logic                       busy,
  output logic [CFG_W-1:0]           cfg_word,
  output logic [15:0]                conv_count,
  output logic                       frame_err
);

  localparam int TIMER_W = $clog2(CONV_CYCLES);
  localparam int CNT_W   = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0]   CFG_CNT   = CNT_W'(CFG_W);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CONV_CYCLES - 1);
  localparam logic [CFG_W-1:0]   CFG_RESET = 6'b100010;
  localparam logic [DATA_W-1:0]  SIGN_BIT  = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_prev_q,   sck_prev_q;

  logic [1:0]         state_q,      state_d;
  logic [TIMER_W-1:0] timer_q,      timer_d;
  logic [DATA_W-1:0]  result_q,     result_d;
  logic [DATA_W-1:0]  shift_q,      shift_d;
  logic [DATA_W-1:0]  sample_q,     sample_d;
  logic [CFG_W-1:0]   cfg_word_q,   cfg_word_d;
  logic [CFG_W-1:0]   cfg_shift_q,  cfg_shift_d;
  logic [CNT_W-1:0]   rise_cnt_q,   rise_cnt_d;
  logic [15:0]        conv_count_q, conv_count_d;
  logic               miso_q,       miso_d;
  logic               frame_err_q,  frame_err_d;

  logic       cs_s, sck_s, mosi_s;
  logic       cs_rise, cs_fall, sck_rise, sck_fall;
  logic       start_conv;
  logic [2:0] ch_sel;

  // SYNC_STAGES must be at least 2 for this shift form.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi.cs};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi.sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    result_d     = result_q;
    shift_d      = shift_q;
    sample_d     = sample_q;
    cfg_word_d   = cfg_word_q;
    cfg_shift_d  = cfg_shift_q;
    rise_cnt_d   = rise_cnt_q;
    conv_count_d = conv_count_q;
    miso_d       = miso_q;
    frame_err_d  = 1'b0;
    start_conv   = 1'b0;
    ch_sel       = 3'd0;

    case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          start_conv = 1'b1;
        end else if (cs_fall) begin
          state_d    = ST_FRAME;
          shift_d    = result_q;
          miso_d     = result_q[DATA_W-1];
          rise_cnt_d = '0;
        end
      end
      ST_CONV: begin
        if (cs_rise) frame_err_d = 1'b1;
        if (timer_q == '0) begin
          if (!cfg_word_q[5]) begin
            result_d    = '0;
            frame_err_d = 1'b1;
          end else if (cfg_word_q[1]) begin
            result_d = sample_q;
          end else begin
            result_d = sample_q ^ SIGN_BIT;
          end
          conv_count_d = conv_count_q + 16'd1;
          // A frame that opened during conversion starts now with the fresh result.
          if (!cs_s) begin
            state_d    = ST_FRAME;
            shift_d    = result_d;
            miso_d     = result_d[DATA_W-1];
            rise_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_FRAME: begin
        if (cs_rise) begin
          start_conv = 1'b1;
          miso_d     = 1'b0;
          if (rise_cnt_q == CFG_CNT) cfg_word_d  = cfg_shift_q;
          else                       frame_err_d = 1'b1;
        end else begin
          if (sck_rise && rise_cnt_q < CFG_CNT) begin
            cfg_shift_d = {cfg_shift_q[CFG_W-2:0], mosi_s};
            rise_cnt_d  = rise_cnt_q + 1'b1;
          end
          if (sck_fall) begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            miso_d  = shift_q[DATA_W-2];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Channel sampled with the config that governs this conversion.
    if (start_conv) begin
      state_d = ST_CONV;
      timer_d = TIMER_MAX;
      ch_sel  = {cfg_word_d[3], cfg_word_d[2], cfg_word_d[4]};
      for (int i = 0; i < 8; i++) begin
        if (ch_sel == 3'(i)) sample_d = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q    <= '1;
      sck_sync_q   <= '0;
      mosi_sync_q  <= '0;
      cs_prev_q    <= 1'b1;
      sck_prev_q   <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      result_q     <= '0;
      shift_q      <= '0;
      sample_q     <= '0;
      cfg_word_q   <= CFG_RESET;
      cfg_shift_q  <= '0;
      rise_cnt_q   <= '0;
      conv_count_q <= '0;
      miso_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      sck_sync_q   <= sck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_prev_q    <= cs_s;
      sck_prev_q   <= sck_s;
      state_q      <= state_d;
      timer_q      <= timer_d;
      result_q     <= result_d;
      shift_q      <= shift_d;
      sample_q     <= sample_d;
      cfg_word_q   <= cfg_word_d;
      cfg_shift_q  <= cfg_shift_d;
      rise_cnt_q   <= rise_cnt_d;
      conv_count_q <= conv_count_d;
      miso_q       <= miso_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign spi.miso   = miso_q;
  assign busy       = (state_q == ST_CONV);
  assign cfg_word   = cfg_word_q;
  assign conv_count = conv_count_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire
